// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath blocks: multiplier FSM states,
// Booth recoding pairs and the default operand width.
package mips_pkg;

    localparam int MB_WIDTH = 32;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [1:0] {
        MB_IDLE = 2'd0,
        MB_RUN  = 2'd1,
        MB_DONE = 2'd2
    } mb_state_e;

endpackage

// File: rtl/mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into acc, then an
// arithmetic right shift of the whole {acc, Q, q_1} chain by one bit.
module booth_step
    import mips_pkg::*;
#(
    parameter int WIDTH = MB_WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            BOOTH_ADD: sum = acc_i + m_i;
            BOOTH_SUB: sum = acc_i - m_i;
            default:   sum = acc_i;
        endcase
    end

    // acc MSB is replicated so the shift stays arithmetic
    assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o   = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o  = q_i[0];

endmodule

// File: rtl/mult_booth.sv
// Sequential signed radix-2 Booth multiplier (MIPS MULT). One iteration per clock,
// product published to hi/lo with a one-cycle mult_stop pulse.
module mult_booth
    import mips_pkg::*;
#(
    parameter int WIDTH = MB_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             mult_stop,
    output logic             mult_busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mb_state_e        state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] qReg_q, qReg_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             stop_q, stop_d;

    logic [WIDTH:0]   stepAcc;
    logic [WIDTH-1:0] stepQ;
    logic             stepQm1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i (acc_q),
        .q_i   (qReg_q),
        .q1_i  (qm1_q),
        .m_i   (m_q),
        .acc_o (stepAcc),
        .q_o   (stepQ),
        .q1_o  (stepQm1)
    );

    // A start in any state reloads the operands, which silently aborts a running op
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        qReg_d  = qReg_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stop_d  = 1'b0;

        if (mult_control) begin
            acc_d   = '0;
            qReg_d  = A;
            qm1_d   = 1'b0;
            m_d     = {B[WIDTH-1], B};
            count_d = CNT_W'(WIDTH);
            state_d = MB_RUN;
        end else begin
            case (state_q)
                MB_IDLE: state_d = MB_IDLE;
                MB_RUN: begin
                    acc_d   = stepAcc;
                    qReg_d  = stepQ;
                    qm1_d   = stepQm1;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = MB_DONE;
                    end
                end
                MB_DONE: begin
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = qReg_q;
                    stop_d  = 1'b1;
                    state_d = MB_IDLE;
                end
                default: state_d = MB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MB_IDLE;
            acc_q   <= '0;
            qReg_q  <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            qReg_q  <= qReg_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            stop_q  <= stop_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign mult_stop = stop_q;
    assign mult_busy = (state_q != MB_IDLE);

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed product table, reset/restart/back-to-back
// sequences and a batch of random operand pairs against a signed 64-bit reference.
module tb_mult_booth;

    logic        clk;
    logic        reset;
    logic        mult_control;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_stop;
    logic        mult_busy;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    vec_t vecs[10];

    mult_booth #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .mult_control (mult_control),
        .A            (A),
        .B            (B),
        .hi           (hi),
        .lo           (lo),
        .mult_stop    (mult_stop),
        .mult_busy    (mult_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the start edge.
    task automatic startOp(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        mult_control = 1'b1;
        @(negedge clk);
        mult_control = 1'b0;
    endtask

    // Counts cycles after the start edge until mult_stop is seen; -1 on timeout.
    task automatic waitDone(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mult_stop) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        int lat;
        startOp(v.a, v.b);
        checkOutput({name, " busy"}, 64'(mult_busy), 64'd1);
        waitDone(lat);
        checkOutput({name, " latency"}, 64'(lat), 64'd33);
        checkOutput({name, " product"}, {hi, lo}, {v.expHi, v.expLo});
        @(negedge clk);
        checkOutput({name, " stop pulse"}, {63'd0, mult_stop}, 64'd0);
        checkOutput({name, " idle"}, {63'd0, mult_busy}, 64'd0);
    endtask

    initial begin
        int lat;
        int stops;
        bit held;
        logic [31:0] ra, rb;
        longint expProd;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'd3,        32'd4,        32'h00000000, 32'h0000000C};
        vecs[1] = '{32'hFFFFFFFB, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[2] = '{32'hFFFFFFFB, 32'hFFFFFFF9, 32'h00000000, 32'd35};
        vecs[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[5] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[7] = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[8] = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
        vecs[9] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        reset = 1'b1;
        mult_control = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset hi/lo", {hi, lo}, 64'd0);
        checkOutput("reset stop/busy", {62'd0, mult_stop, mult_busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of an operation
        startOp(32'd6, 32'd9);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset hi/lo", {hi, lo}, 64'd0);
        checkOutput("midreset stop/busy", {62'd0, mult_stop, mult_busy}, 64'd0);
        stops = 0;
        repeat (40) begin
            @(negedge clk);
            if (mult_stop) stops++;
        end
        checkOutput("midreset no stop", 64'(stops), 64'd0);

        // Restart while running: only the second op completes
        startOp(32'd2, 32'd3);
        repeat (4) @(negedge clk);
        startOp(32'd10, 32'hFFFFFFF6);
        waitDone(lat);
        checkOutput("restart latency", 64'(lat), 64'd33);
        checkOutput("restart product", {hi, lo}, 64'hFFFFFFFF_FFFFFF9C);
        stops = 0;
        repeat (40) begin
            @(negedge clk);
            if (mult_stop) stops++;
        end
        checkOutput("restart single stop", 64'(stops), 64'd0);

        // Back-to-back: start on the edge that clears mult_stop
        startOp(32'd7, 32'd6);
        waitDone(lat);
        checkOutput("b2b first product", {hi, lo}, 64'd42);
        startOp(32'd1, 32'hFFFFFFFF);
        checkOutput("b2b busy", {63'd0, mult_busy}, 64'd1);
        lat = -1;
        held = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mult_stop) begin
                lat = k;
                break;
            end
            if ({hi, lo} !== 64'd42) held = 1'b0;
        end
        checkOutput("b2b held", {63'd0, held}, 64'd1);
        checkOutput("b2b latency", 64'(lat), 64'd33);
        checkOutput("b2b product", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 5 == 0) ra[31:1] = {31{ra[31]}};
            expProd = longint'($signed(ra)) * longint'($signed(rb));
            startOp(ra, rb);
            waitDone(lat);
            checkOutput($sformatf("rand%0d %h*%h", n, ra, rb), {hi, lo}, 64'(expProd));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
